fnd_scan_decoder: RTL and testbench

FND_SCAN_DECODER -- requirements
Module: fnd_scan_decoder

---
 rtl/fnd_pkg.sv | 81 ++++++++
 rtl/fnd_scan_decoder_if.sv | 32 +++
 rtl/fnd_glyph_decode.sv | 51 +++++
 rtl/fnd_scan_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_fnd_scan_decoder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fnd_pkg.sv
// ---------------------------------------------------------------------------
// fnd_pkg -- shared constants and helpers for the 7-segment scan decoder.
//
// Contents:
//   SEG_*      active-low segment patterns {dp,g,f,e,d,c,b,a}
//   CODE_*     glyph codes reported on the digits output
//   AN_*       active-low anode one-hot patterns (bit0 = ones digit)
//   glyph_t    result of the segment lookup (code, undecodable, chase step)
//   helpers    anode classification, anode-to-slot, frame-to-binary
// ---------------------------------------------------------------------------
package fnd_pkg;

    // Numeric glyphs 0..9, indexed by the digit value.
    localparam logic [7:0] SEG_DIGIT [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    // Non-numeric glyphs that make up the marker frame.
    localparam logic [7:0] SEG_C    = 8'hC6;   // "C"
    localparam logic [7:0] SEG_EQ   = 8'hF6;   // top + bottom bars
    localparam logic [7:0] SEG_RBRK = 8'hF0;   // reversed "C"
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Single lit segment a..f: the steps of a chase animation.
    localparam logic [7:0] SEG_ANIM [6] = '{
        8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF
    };

    localparam logic [3:0] CODE_C    = 4'd12;
    localparam logic [3:0] CODE_EQ   = 4'd13;
    localparam logic [3:0] CODE_RBRK = 4'd15;
    localparam logic [3:0] CODE_BAD  = 4'hF;

    localparam logic [15:0] MARKER_DIGITS = {CODE_C, CODE_EQ, CODE_EQ, CODE_RBRK};
    localparam logic [13:0] MARKER_VALUE  = 14'd11111;

    localparam logic [3:0] AN_D1     = 4'b1110;
    localparam logic [3:0] AN_D10    = 4'b1101;
    localparam logic [3:0] AN_D100   = 4'b1011;
    localparam logic [3:0] AN_D1000  = 4'b0111;
    localparam logic [3:0] AN_BLANK  = 4'b1111;

    typedef struct packed {
        logic [3:0] code;
        logic       bad;
        logic       anim;
    } glyph_t;

    typedef enum logic [1:0] {
        AN_IDLE,     // no digit driven
        AN_SINGLE,   // exactly one digit driven
        AN_MULTI     // several digits driven at once: wiring/scan fault
    } an_class_e;

    function automatic an_class_e classify_an(input logic [3:0] an);
        if (an == AN_BLANK) begin
            return AN_IDLE;
        end else if ($onehot(~an)) begin
            return AN_SINGLE;
        end else begin
            return AN_MULTI;
        end
    endfunction

    function automatic logic [1:0] an_to_slot(input logic [3:0] an);
        case (an)
            AN_D10:   return 2'd1;
            AN_D100:  return 2'd2;
            AN_D1000: return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

    // d[3] is the thousands digit; every field is known to be 0..9 here.
    function automatic logic [13:0] frame_to_bin(input logic [3:0][3:0] d);
        return 14'(d[3]) * 14'd1000 + 14'(d[2]) * 14'd100
             + 14'(d[1]) * 14'd10   + 14'(d[0]);
    endfunction

endpackage

// File: rtl/fnd_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// fnd_scan_decoder_if -- bundle of the scanned display lines and the decoded
// frame outputs.
//
//   master : the display driver side, drives an/seg, observes results
//   slave  : the decoder side, observes an/seg, drives results
// ---------------------------------------------------------------------------
interface fnd_scan_decoder_if;

    logic [3:0]  an;
    logic [7:0]  seg;
    logic [13:0] value;
    logic [15:0] digits;
    logic        frame_valid;
    logic        frame_strobe;
    logic        marker;
    logic        anim_detect;
    logic        err_glyph;

    modport master (
        output an, seg,
        input  value, digits, frame_valid, frame_strobe,
               marker, anim_detect, err_glyph
    );

    modport slave (
        input  an, seg,
        output value, digits, frame_valid, frame_strobe,
               marker, anim_detect, err_glyph
    );

endinterface

// File: rtl/fnd_glyph_decode.sv
// ---------------------------------------------------------------------------
// fnd_glyph_decode -- purely combinational segment-pattern lookup.
//
// Ports:
//   seg   in  8  active-low segment lines {dp,g,f,e,d,c,b,a}
//   glyph out    {code, bad, anim}
//                 digits 0..9 -> code 0..9, C6/F6/F0 -> 12/13/15,
//                 single-segment chase steps -> anim=1,
//                 anything else -> code 4'hF with bad=1
// ---------------------------------------------------------------------------
module fnd_glyph_decode
    import fnd_pkg::*;
(
    input  logic [7:0] seg,
    output glyph_t     glyph
);

    logic [9:0] digit_hit;
    logic [5:0] anim_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_digit
            assign digit_hit[gi] = (seg == SEG_DIGIT[gi]);
        end
        for (gi = 0; gi < 6; gi++) begin : g_anim
            assign anim_hit[gi] = (seg == SEG_ANIM[gi]);
        end
    endgenerate

    always_comb begin
        glyph = '{code: CODE_BAD, bad: 1'b1, anim: 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (digit_hit[i]) begin
                glyph.code = 4'(i);
                glyph.bad  = 1'b0;
            end
        end
        case (seg)
            SEG_C:    glyph = '{code: CODE_C,    bad: 1'b0, anim: 1'b0};
            SEG_EQ:   glyph = '{code: CODE_EQ,   bad: 1'b0, anim: 1'b0};
            SEG_RBRK: glyph = '{code: CODE_RBRK, bad: 1'b0, anim: 1'b0};
            default:  ;
        endcase
        // Chase steps carry no digit code; the slot logic never stores them.
        if (|anim_hit) begin
            glyph = '{code: CODE_BAD, bad: 1'b0, anim: 1'b1};
        end
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// ---------------------------------------------------------------------------
// fnd_scan_decoder -- reconstructs the number shown on a 4-digit multiplexed
// 7-segment display by watching its anode and segment lines.
//
// Parameters:
//   STABLE_CYCLES   consecutive unchanged cycles of {an,seg} before sampling
//   TIMEOUT_CYCLES  cycles without a sample before the frame state is dropped
//
// Ports:
//   clk           in   1   system clock
//   reset_n       in   1   asynchronous active-low reset
//   an            in   4   active-low anodes, bit0 = ones digit
//   seg           in   8   active-low segments {dp,g,f,e,d,c,b,a}
//   value         out  14  binary value of the last good frame
//   digits        out  16  glyph codes of the last complete frame
//   frame_valid   out  1   last frame decodable and no timeout since
//   frame_strobe  out  1   one-cycle pulse per completed frame
//   marker        out  1   last frame was the C == ] marker
//   anim_detect   out  1   single-segment chase seen
//   err_glyph     out  1   sticky undecodable-glyph / multi-anode flag
// ---------------------------------------------------------------------------
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [13:0] value,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic        frame_strobe,
    output logic        marker,
    output logic        anim_detect,
    output logic        err_glyph
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_FULL = STAB_W'(STABLE_CYCLES);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    // ---------------- state ----------------
    logic [11:0]       scan_prev_reg;
    logic [STAB_W-1:0] stab_cnt_reg,  stab_cnt_next;
    logic [TO_W-1:0]   to_cnt_reg,    to_cnt_next;
    logic [3:0][3:0]   slot_code_reg, slot_code_next;
    logic [3:0]        slot_bad_reg,  slot_bad_next;
    logic [3:0]        seen_reg,      seen_next;
    logic [15:0]       digits_reg,    digits_next;
    logic [13:0]       value_reg,     value_next;
    logic              valid_reg,     valid_next;
    logic              strobe_reg,    strobe_next;
    logic              marker_reg,    marker_next;
    logic              anim_reg,      anim_next;
    logic              err_reg,       err_next;

    // ---------------- combinational helpers ----------------
    glyph_t     glyph;
    an_class_e  an_class;
    logic [1:0] slot_idx;
    logic       scan_same;
    logic       sample;
    logic       timeout;
    logic       frame_done;
    logic [3:0] slot_is_num;
    logic       frame_numeric;
    logic       frame_marker;

    fnd_glyph_decode u_glyph (
        .seg   (seg),
        .glyph (glyph)
    );

    assign an_class  = classify_an(an);
    assign slot_idx  = an_to_slot(an);
    assign scan_same = ({an, seg} == scan_prev_reg);
    // Fires exactly when the run of unchanged cycles reaches STABLE_CYCLES;
    // the counter then saturates, so a long steady digit samples only once.
    assign sample    = scan_same && (stab_cnt_reg == STAB_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign slot_is_num[gi] = !slot_bad_reg[gi] && (slot_code_reg[gi] <= 4'd9);
        end
    endgenerate

    assign frame_numeric = &slot_is_num;
    assign frame_marker  = (slot_code_reg == MARKER_DIGITS) && (slot_bad_reg == 4'b0000);
    assign frame_done    = (seen_reg == 4'b1111);

    always_comb begin
        stab_cnt_next  = stab_cnt_reg;
        to_cnt_next    = to_cnt_reg + TO_W'(1);
        slot_code_next = slot_code_reg;
        slot_bad_next  = slot_bad_reg;
        seen_next      = seen_reg;
        digits_next    = digits_reg;
        value_next     = value_reg;
        valid_next     = valid_reg;
        strobe_next    = 1'b0;
        marker_next    = marker_reg;
        anim_next      = anim_reg;
        err_next       = err_reg;
        timeout        = 1'b0;

        // Stability run length.
        if (!scan_same) begin
            stab_cnt_next = '0;
        end else if (stab_cnt_reg != STAB_FULL) begin
            stab_cnt_next = stab_cnt_reg + STAB_W'(1);
        end

        // Idle watchdog; a sample in the same cycle always wins.
        if (sample) begin
            to_cnt_next = '0;
        end else if (to_cnt_reg == TO_LAST) begin
            to_cnt_next = '0;
            timeout     = 1'b1;
        end

        if (timeout) begin
            seen_next  = 4'b0000;
            valid_next = 1'b0;
            anim_next  = 1'b0;
        end

        // Frame completion is evaluated on the registered seen vector, so
        // outputs change one cycle after the fourth slot is filled.
        if (frame_done) begin
            seen_next   = 4'b0000;
            strobe_next = 1'b1;
            digits_next = slot_code_reg;
            if (frame_numeric) begin
                value_next  = frame_to_bin(slot_code_reg);
                valid_next  = 1'b1;
                marker_next = 1'b0;
                anim_next   = 1'b0;
                err_next    = 1'b0;
            end else if (frame_marker) begin
                value_next  = MARKER_VALUE;
                valid_next  = 1'b1;
                marker_next = 1'b1;
                err_next    = 1'b0;
            end else begin
                valid_next  = 1'b0;
                marker_next = 1'b0;
            end
        end

        // Handled last so a sample landing in the completion cycle opens the
        // next frame instead of being wiped by the seen clear above.
        if (sample) begin
            case (an_class)
                AN_MULTI: err_next = 1'b1;
                AN_SINGLE: begin
                    if (glyph.anim) begin
                        anim_next = 1'b1;
                    end else begin
                        slot_code_next[slot_idx] = glyph.code;
                        slot_bad_next[slot_idx]  = glyph.bad;
                        seen_next[slot_idx]      = 1'b1;
                        if (glyph.bad) begin
                            err_next = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_prev_reg <= {AN_BLANK, SEG_BLANK};
            stab_cnt_reg  <= '0;
            to_cnt_reg    <= '0;
            slot_code_reg <= {4{CODE_BAD}};
            slot_bad_reg  <= 4'b0000;
            seen_reg      <= 4'b0000;
            digits_reg    <= 16'hFFFF;
            value_reg     <= '0;
            valid_reg     <= 1'b0;
            strobe_reg    <= 1'b0;
            marker_reg    <= 1'b0;
            anim_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            scan_prev_reg <= {an, seg};
            stab_cnt_reg  <= stab_cnt_next;
            to_cnt_reg    <= to_cnt_next;
            slot_code_reg <= slot_code_next;
            slot_bad_reg  <= slot_bad_next;
            seen_reg      <= seen_next;
            digits_reg    <= digits_next;
            value_reg     <= value_next;
            valid_reg     <= valid_next;
            strobe_reg    <= strobe_next;
            marker_reg    <= marker_next;
            anim_reg      <= anim_next;
            err_reg       <= err_next;
        end
    end

    assign value        = value_reg;
    assign digits       = digits_reg;
    assign frame_valid  = valid_reg;
    assign frame_strobe = strobe_reg;
    assign marker       = marker_reg;
    assign anim_detect  = anim_reg;
    assign err_glyph    = err_reg;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_fnd_scan_decoder -- scoreboard bench for fnd_scan_decoder.
// Each scanned frame pushes its expected result; the strobe monitor pops and
// compares. Direct checks cover reset, error, animation and timeout states.
// ---------------------------------------------------------------------------
module tb_fnd_scan_decoder;
    import fnd_pkg::*;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 64;
    localparam int HOLD    = 5;

    typedef struct {
        logic [13:0] value;
        logic [15:0] digits;
        logic        valid;
        logic        marker;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fnd_scan_decoder_if bus ();

    fnd_scan_decoder #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .an           (bus.an),
        .seg          (bus.seg),
        .value        (bus.value),
        .digits       (bus.digits),
        .frame_valid  (bus.frame_valid),
        .frame_strobe (bus.frame_strobe),
        .marker       (bus.marker),
        .anim_detect  (bus.anim_detect),
        .err_glyph    (bus.err_glyph)
    );

    logic [7:0] tb_seg [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [7:0] tb_chase [6] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};

    exp_t sb_q [$];
    exp_t sb_e;
    int   err_cnt    = 0;
    int   chk_cnt    = 0;
    int   strobe_cnt = 0;
    int   strobe_mark;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge n cycles later.
    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        bus.an  = a;
        bus.seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        hold(AN_BLANK, 8'hFF, 6);
        check_eq({tag, "_drained"}, 32'(sb_q.size()), 0);
    endtask

    task automatic push_num(input int d3, input int d2, input int d1, input int d0);
        sb_q.push_back('{value:  14'(d3 * 1000 + d2 * 100 + d1 * 10 + d0),
                         digits: {4'(d3), 4'(d2), 4'(d1), 4'(d0)},
                         valid: 1'b1, marker: 1'b0, err: 1'b0});
    endtask

    task automatic scan_num(input string tag, input int d3, input int d2, input int d1, input int d0);
        push_num(d3, d2, d1, d0);
        hold(4'b0111, tb_seg[d3], HOLD);
        hold(4'b1011, tb_seg[d2], HOLD);
        hold(4'b1101, tb_seg[d1], HOLD);
        hold(4'b1110, tb_seg[d0], HOLD);
        drain(tag);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_value"},  32'(bus.value), 0);
        check_eq({tag, "_digits"}, 32'(bus.digits), 32'h0000FFFF);
        check_eq({tag, "_valid"},  32'(bus.frame_valid), 0);
        check_eq({tag, "_strobe"}, 32'(bus.frame_strobe), 0);
        check_eq({tag, "_marker"}, 32'(bus.marker), 0);
        check_eq({tag, "_anim"},   32'(bus.anim_detect), 0);
        check_eq({tag, "_err"},    32'(bus.err_glyph), 0);
    endtask

    // Strobe monitor: one line per completed frame, compared to the queue head.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.frame_strobe === 1'b1) begin
            strobe_cnt++;
            $display("frame: digits=%h value=%0d valid=%0b marker=%0b err=%0b anim=%0b",
                     bus.digits, bus.value, bus.frame_valid, bus.marker,
                     bus.err_glyph, bus.anim_detect);
            check_eq("strobe_expected", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                sb_e = sb_q.pop_front();
                check_eq("frm_value",  32'(bus.value),       32'(sb_e.value));
                check_eq("frm_digits", 32'(bus.digits),      32'(sb_e.digits));
                check_eq("frm_valid",  32'(bus.frame_valid), 32'(sb_e.valid));
                check_eq("frm_marker", 32'(bus.marker),      32'(sb_e.marker));
                check_eq("frm_err",    32'(bus.err_glyph),   32'(sb_e.err));
            end
        end
    end

    initial begin
        bus.an  = AN_BLANK;
        bus.seg = 8'hFF;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // Plain numeric frame.
        scan_num("f1234", 1, 2, 3, 4);

        // Marker frame.
        sb_q.push_back('{value: 14'd11111, digits: 16'hCDDF, valid: 1'b1, marker: 1'b1, err: 1'b0});
        hold(4'b0111, 8'hC6, HOLD);
        hold(4'b1011, 8'hF6, HOLD);
        hold(4'b1101, 8'hF6, HOLD);
        hold(4'b1110, 8'hF0, HOLD);
        drain("marker");

        // Short "8" glitch inside a steady "5" must not be sampled.
        push_num(0, 0, 0, 5);
        hold(4'b0111, tb_seg[0], HOLD);
        hold(4'b1011, tb_seg[0], HOLD);
        hold(4'b1101, tb_seg[0], HOLD);
        hold(4'b1110, tb_seg[5], 2);
        hold(4'b1110, tb_seg[8], 2);
        hold(4'b1110, tb_seg[5], HOLD);
        drain("glitch");

        // Undecodable glyph in the ones digit: value holds at 5.
        sb_q.push_back('{value: 14'd5, digits: 16'h123F, valid: 1'b0, marker: 1'b0, err: 1'b1});
        hold(4'b0111, tb_seg[1], HOLD);
        hold(4'b1011, tb_seg[2], HOLD);
        hold(4'b1101, tb_seg[3], HOLD);
        hold(4'b1110, 8'hFF, HOLD);
        drain("badglyph");
        check_eq("bad_err_sticky", 32'(bus.err_glyph), 1);

        // Next good frame clears the error.
        scan_num("f0042", 0, 0, 4, 2);

        // Two anodes low at once: flagged, no frame activity.
        strobe_mark = strobe_cnt;
        hold(4'b1100, tb_seg[0], HOLD);
        hold(AN_BLANK, 8'hFF, 2);
        check_eq("multi_err",   32'(bus.err_glyph), 1);
        check_eq("multi_valid", 32'(bus.frame_valid), 1);
        check_eq("multi_value", 32'(bus.value), 42);

        // Chase animation, then frozen inputs until the watchdog expires.
        for (int i = 0; i < 6; i++) begin
            hold(4'b1110, tb_chase[i], HOLD);
        end
        check_eq("chase_anim",     32'(bus.anim_detect), 1);
        check_eq("chase_nostrobe", 32'(strobe_cnt), 32'(strobe_mark));
        hold(4'b1110, tb_chase[5], TIMEOUT - 10);
        check_eq("pre_to_valid", 32'(bus.frame_valid), 1);
        check_eq("pre_to_anim",  32'(bus.anim_detect), 1);
        hold(4'b1110, tb_chase[5], 15);
        check_eq("to_anim",   32'(bus.anim_detect), 0);
        check_eq("to_valid",  32'(bus.frame_valid), 0);
        check_eq("to_value",  32'(bus.value), 42);
        check_eq("to_digits", 32'(bus.digits), 32'h00000042);
        check_eq("to_nostrobe", 32'(strobe_cnt), 32'(strobe_mark));
        hold(AN_BLANK, 8'hFF, 3);

        // Reset in the middle of a frame discards the partial digits.
        hold(4'b1110, tb_seg[6], HOLD);
        hold(4'b1101, tb_seg[7], HOLD);
        reset_n = 1'b0;
        hold(AN_BLANK, 8'hFF, 2);
        check_reset_state("midrst");
        reset_n = 1'b1;
        @(negedge clk);
        strobe_mark = strobe_cnt;
        push_num(9, 8, 7, 6);
        hold(4'b0111, tb_seg[9], HOLD);
        hold(4'b1011, tb_seg[8], HOLD);
        hold(4'b1101, tb_seg[7], HOLD);
        check_eq("rst_no_early_strobe", 32'(strobe_cnt), 32'(strobe_mark));
        hold(4'b1110, tb_seg[6], HOLD);
        drain("f9876");
        check_eq("rst_one_strobe", 32'(strobe_cnt - strobe_mark), 1);
        check_eq("rst_value", 32'(bus.value), 9876);

        check_eq("sb_empty", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
